alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
- Shares one add/sub ALU (32-bit operands, 1-bit op: 0 = add, 1 = sub, Z/N/C/V flags) among NREQ VLIW issue slots.
- Each cycle, a round-robin grant selects at most one requesting slot and drives its operands onto the ALU.
- Captures the ALU result and flags, tagged with the slot ID, in a single-entry output register with valid/ready backpressure.
- Sits between the decode/issue stage and the writeback arbiter.

Parameters:
- NREQ, 4, number of requesting issue slots (2..8).
- W, 32, operand and result width.
- IDW, 2, width of the slot-ID tag; must equal max(1, clog2(NREQ)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  NREQ  per-slot request; slot i held high until gnt[i].
- req_in1  input  NREQ*W  slot i operand 1 at bits [i*W +: W].
- req_in2  input  NREQ*W  slot i operand 2 at bits [i*W +: W].
- req_op  input  NREQ  slot i ALU op (0 = add, 1 = sub).
- gnt  output  NREQ  one-hot (or zero) grant, combinational, same cycle as the accepted request.
- aluIn1  output  W  to ALU operand 1.
- aluIn2  output  W  to ALU operand 2.
- aluOp  output  1  to ALU op select.
- aluOut  input  W  ALU result (combinational from aluIn1/aluIn2/aluOp).
- flag_z, flag_n, flag_c, flag_v  input  1 each  ALU flags, same cycle as aluOut.
- resp_valid  output  1  output register holds a result.
- resp_ready  input  1  consumer accepts the result this cycle.
- resp_id  output  IDW  slot index of the held result.
- resp_data  output  W  held result.
- resp_flags  output  4  held flags as {z, n, c, v}.

Behaviour:
- Reset values: resp_valid = 0, resp_id = 0, resp_data = 0, resp_flags = 0, priority pointer ptr = 0. gnt is all-zero and aluIn1/aluIn2/aluOp are 0 while reset is asserted.
- can_issue = !resp_valid || resp_ready.
- Grant: when can_issue and |req, grant the first set req bit scanning ptr, ptr+1, …, NREQ-1, 0, … (modulo NREQ). Exactly one gnt bit is high.
  - When !can_issue or no request, gnt = 0.
- ALU drive:
  - Granted cycle: aluIn1/aluIn2/aluOp = the winner's operands and op.
  - Otherwise: all 0 (add of zeros).
  - Inputs are never driven from a non-granted slot.
- Capture: on the edge ending a granted cycle, resp_data <= aluOut, resp_flags <= {flag_z, flag_n, flag_c, flag_v}, resp_id <= winner index, resp_valid <= 1, ptr <= (winner+1) mod NREQ.
- Latency: request granted in cycle t produces resp_valid in cycle t+1. Throughput is 1 result/cycle while resp_ready = 1.
- Drain: when resp_valid && resp_ready and no grant in that cycle, resp_valid <= 0 next edge. Data/id/flags hold their last values.
- Simultaneous accept + grant: when resp_valid && resp_ready and a grant occurs in the same cycle, the new result replaces the old one and resp_valid stays 1. No bubble.
- Backpressure: while resp_valid && !resp_ready, no grant is issued. resp_* are held stable; the held value must not change while valid and not ready. ptr is unchanged.
- ptr moves only on a grant. A slot that holds req is served within NREQ grants (starvation-free).
- A requester dropping req without a grant is legal and is simply not served. Operands are sampled only in the granted cycle.
- Flags are passed through exactly as produced by the ALU; this block does no flag arithmetic.
- Reset mid-operation: a held, unaccepted result is discarded (resp_valid -> 0 asynchronously). ptr -> 0. Requesters must re-present.
- Out-of-range ptr (NREQ not a power of two) cannot occur: ptr wraps to 0 after NREQ-1.

Test Plan:
- Single request: reset, then req = 0001, in1 = 5, in2 = 3, op = 0, resp_ready = 1 -> gnt = 0001 same cycle; next cycle resp_valid = 1, resp_id = 0, resp_data = 8, resp_flags = 0000; ptr = 1.
- Round-robin fairness: all four slots request continuously, resp_ready = 1 -> grants in order 0, 1, 2, 3, 0, 1; resp_id follows one cycle later with no gaps.
- Backpressure: slot 2 sub 7-7 granted, then resp_ready = 0 for 3 cycles with slot 3 requesting -> resp_data = 0 and z = 1 held stable, gnt = 0 during stall; slot 3 granted in the cycle resp_ready returns to 1, with no bubble.
- Wrap and flags: ptr = 3, slots 1 and 3 request -> slot 3 granted first, then slot 1. Slot 1 computes 0x80000000 - 1 -> resp_data = 0x7FFFFFFF with v = 1 passed through from the ALU.
- Reset mid-operation: result held with resp_ready = 0, then reset pulsed asynchronously between edges -> resp_valid = 0 immediately; after release, slot 0 is granted first.

Source files
------------

// File: rtl/alu_issue_arbiter_if.sv
// alu_issue_arbiter_if: issue-slot requests, shared ALU drive and tagged result handshake
interface alu_issue_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W = 32,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] req_in1;
  logic [NREQ*W-1:0] req_in2;
  logic [NREQ-1:0] req_op;
  logic [NREQ-1:0] gnt;
  logic [W-1:0] aluIn1;
  logic [W-1:0] aluIn2;
  logic aluOp;
  logic [W-1:0] aluOut;
  logic flag_z;
  logic flag_n;
  logic flag_c;
  logic flag_v;
  logic resp_valid;
  logic resp_ready;
  logic [IDW-1:0] resp_id;
  logic [W-1:0] resp_data;
  logic [3:0] resp_flags;
  modport master (
    output req, req_in1, req_in2, req_op, aluOut, flag_z, flag_n, flag_c, flag_v, resp_ready,
    input gnt, aluIn1, aluIn2, aluOp, resp_valid, resp_id, resp_data, resp_flags
  );
  modport slave (
    input req, req_in1, req_in2, req_op, aluOut, flag_z, flag_n, flag_c, flag_v, resp_ready,
    output gnt, aluIn1, aluIn2, aluOp, resp_valid, resp_id, resp_data, resp_flags
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin share of one add/sub ALU among issue slots, result held in a valid/ready register
module alu_issue_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 32,
  parameter int IDW = 2
) (
  input logic clk,
  input logic reset,
  alu_issue_arbiter_if.slave bus
);
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic r_valid;
  logic [W-1:0] r_data;
  logic [3:0] r_flags;
  logic [IDW:0] w_idx;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_nxt;
  logic w_hit;
  logic w_go;
  // scan from the farthest slot back toward ptr so the closest requester wins last
  always_comb begin
    w_win = '0;
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      w_idx = (w_idx >= (IDW+1)'(NREQ)) ? w_idx - (IDW+1)'(NREQ) : w_idx;
      if (bus.req[w_idx[IDW-1:0]]) begin
        w_hit = 1'b1;
        w_win = w_idx[IDW-1:0];
      end
    end
  end
  assign w_go = w_hit && (!r_valid || bus.resp_ready) && !reset;
  assign w_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  assign bus.gnt = w_go ? NREQ'(1) << w_win : '0;
  assign bus.aluIn1 = w_go ? bus.req_in1[w_win*W +: W] : '0;
  assign bus.aluIn2 = w_go ? bus.req_in2[w_win*W +: W] : '0;
  assign bus.aluOp = w_go && bus.req_op[w_win];
  assign bus.resp_valid = r_valid;
  assign bus.resp_id = r_id;
  assign bus.resp_data = r_data;
  assign bus.resp_flags = r_flags;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      r_id <= '0;
      r_valid <= 1'b0;
      r_data <= '0;
      r_flags <= '0;
    end else if (w_go) begin
      r_ptr <= w_nxt;
      r_id <= w_win;
      r_valid <= 1'b1;
      r_data <= bus.aluOut;
      r_flags <= {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
    end else if (bus.resp_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: random traffic checked every cycle against a behavioural model, plus directed scenarios
module tb_alu_issue_arbiter;
  localparam int NREQ = 4;
  localparam int W = 32;
  localparam int IDW = 2;
  logic clk;
  logic reset;
  int checks = 0;
  int errors = 0;
  int m_ptr;
  logic m_valid;
  logic [IDW-1:0] m_id;
  logic [W-1:0] m_data;
  logic [3:0] m_flags;
  alu_issue_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();
  alu_issue_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [32:0] s;
    logic [31:0] r;
    logic v;
    s = op ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, a} + {1'b0, b};
    r = s[31:0];
    v = op ? (a[31] != b[31]) && (r[31] != a[31]) : (a[31] == b[31]) && (r[31] != a[31]);
    return {r == 0, r[31], s[32], v, r};
  endfunction
  assign {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.aluOut} = alu_f(bus.aluIn1, bus.aluIn2, bus.aluOp);
  function automatic int winner();
    if (reset || (m_valid && !bus.resp_ready)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge reset) begin
    int s;
    if (reset) begin
      m_ptr <= 0;
      m_valid <= 1'b0;
      m_id <= '0;
      m_data <= '0;
      m_flags <= '0;
    end else begin
      s = winner();
      if (s >= 0) begin
        {m_flags, m_data} <= alu_f(bus.req_in1[s*W +: W], bus.req_in2[s*W +: W], bus.req_op[s]);
        m_id <= IDW'(s);
        m_valid <= 1'b1;
        m_ptr <= (s + 1) % NREQ;
      end else if (bus.resp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
  always @(negedge clk) begin
    int s;
    s = winner();
    chk("gnt", bus.gnt, s < 0 ? 0 : 1 << s);
    chk("alu_in1", bus.aluIn1, s < 0 ? 0 : bus.req_in1[s*W +: W]);
    chk("alu_in2", bus.aluIn2, s < 0 ? 0 : bus.req_in2[s*W +: W]);
    chk("alu_op", bus.aluOp, s < 0 ? 0 : bus.req_op[s]);
    chk("resp_valid", bus.resp_valid, m_valid);
    chk("resp_id", bus.resp_id, m_id);
    chk("resp_data", bus.resp_data, m_data);
    chk("resp_flags", bus.resp_flags, m_flags);
  end
  task automatic set_slot(input int s, input logic [31:0] a, input logic [31:0] b, input logic op);
    bus.req_in1[s*W +: W] = a;
    bus.req_in2[s*W +: W] = b;
    bus.req_op[s] = op;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  function automatic logic [31:0] rand_word();
    int c;
    c = $urandom_range(0, 5);
    return c == 0 ? 32'h0 : c == 1 ? 32'h8000_0000 : c == 2 ? 32'hFFFF_FFFF : c == 3 ? 32'h7FFF_FFFF : $urandom;
  endfunction
  initial begin
    int rr[6] = '{0, 1, 2, 3, 0, 1};
    reset = 1'b1;
    bus.req = '0;
    bus.req_in1 = '0;
    bus.req_in2 = '0;
    bus.req_op = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    set_slot(0, 5, 3, 0);
    bus.req = 4'b0001;
    @(negedge clk) chk("single_gnt", bus.gnt, 4'b0001);
    @(posedge clk);
    #1 bus.req = '0;
    @(negedge clk);
    chk("single_valid", bus.resp_valid, 1);
    chk("single_id", bus.resp_id, 0);
    chk("single_data", bus.resp_data, 8);
    chk("single_flags", bus.resp_flags, 4'b0000);
    do_reset();
    for (int s = 0; s < NREQ; s++) set_slot(s, $urandom, $urandom, 1'($urandom));
    bus.req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_gnt", bus.gnt, 1 << rr[i]);
      if (i > 0) begin
        chk("rr_valid", bus.resp_valid, 1);
        chk("rr_id", bus.resp_id, rr[i-1]);
      end
      @(posedge clk);
      #1;
    end
    bus.req = '0;
    do_reset();
    set_slot(2, 7, 7, 1);
    set_slot(3, 10, 20, 0);
    bus.req = 4'b0100;
    @(negedge clk) chk("bp_first_gnt", bus.gnt, 4'b0100);
    @(posedge clk);
    #1 bus.req = 4'b1000;
    bus.resp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_gnt", bus.gnt, 0);
      chk("bp_stall_valid", bus.resp_valid, 1);
      chk("bp_stall_data", bus.resp_data, 0);
      chk("bp_stall_z", bus.resp_flags[3], 1);
      @(posedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk) chk("bp_resume_gnt", bus.gnt, 4'b1000);
    @(posedge clk);
    #1 bus.req = '0;
    @(negedge clk);
    chk("bp_resume_id", bus.resp_id, 3);
    chk("bp_resume_data", bus.resp_data, 30);
    do_reset();
    set_slot(2, 1, 1, 0);
    bus.req = 4'b0100;
    @(posedge clk);
    #1 bus.req = 4'b1010;
    set_slot(1, 32'h8000_0000, 1, 1);
    set_slot(3, 2, 2, 0);
    @(negedge clk) chk("wrap_first", bus.gnt, 4'b1000);
    @(posedge clk);
    #1;
    @(negedge clk) chk("wrap_second", bus.gnt, 4'b0010);
    @(posedge clk);
    #1 bus.req = '0;
    @(negedge clk);
    chk("wrap_id", bus.resp_id, 1);
    chk("wrap_data", bus.resp_data, 32'h7FFF_FFFF);
    chk("wrap_v", bus.resp_flags[0], 1);
    @(posedge clk);
    #1 bus.req = 4'b0010;
    @(posedge clk);
    #1 bus.req = '0;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_async_valid", bus.resp_valid, 0);
    chk("rst_async_data", bus.resp_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.req = 4'b1111;
    bus.resp_ready = 1'b1;
    @(negedge clk) chk("rst_first_gnt", bus.gnt, 4'b0001);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      bus.req = 4'($urandom);
      bus.resp_ready = $urandom_range(0, 3) != 0;
      for (int s = 0; s < NREQ; s++) set_slot(s, rand_word(), rand_word(), 1'($urandom));
    end
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
